fir_mac_seq: RTL and testbench

//  Time-multiplexed FIR sequencer wrapped around the saturating fixed-point multiplier stage.
//  - Holds a TAPS-deep sample delay line.
//  - For each accepted input sample, drives one (sample, coefficient) pair per cycle into the

---
 rtl/fir_mac_seq.sv | 109 ++++++++++
 tb/tb_fir_mac_seq.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/fir_mac_seq.sv
// Time-multiplexed FIR sequencer: one MAC per cycle through an
// external multiplier and coefficient ROM, saturating accumulate.
module fir_mac_seq #(
  parameter int SIZE = 21,
  parameter int TAPS = 8,
  parameter int CW   = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [SIZE-1:0] sample_in,
  input  logic            sample_valid,
  output logic            ready,
  output logic [CW-1:0]   coef_idx,
  input  logic [SIZE-1:0] coef,
  output logic [SIZE-1:0] mul_a,
  output logic [SIZE-1:0] mul_b,
  input  logic [SIZE-1:0] mul_p,
  output logic [SIZE-1:0] y_out,
  output logic            y_valid
);

  typedef enum logic {
    IDLE,
    MAC
  } state_t;

  localparam logic [CW-1:0] KLAST = CW'(TAPS - 1);
  localparam logic [SIZE-1:0] SMAX = {1'b0, {(SIZE-1){1'b1}}};
  localparam logic [SIZE-1:0] SMIN = {1'b1, {(SIZE-1){1'b0}}};

  state_t          state;
  state_t          state_nx;
  logic [CW-1:0]   k;
  logic [SIZE-1:0] acc;
  logic [SIZE-1:0] sum;
  logic [SIZE-1:0] raw;
  logic [SIZE-1:0] x [TAPS];

  // Overflow only when both operands share a sign the sum lost.
  always_comb begin
    raw = acc + mul_p;
    sum = raw;
    if (!acc[SIZE-1] && !mul_p[SIZE-1] && raw[SIZE-1])
      sum = SMAX;
    else if (acc[SIZE-1] && mul_p[SIZE-1] && !raw[SIZE-1])
      sum = SMIN;
  end

  always_comb begin
    state_nx = state;
    ready    = 1'b0;
    coef_idx = '0;
    mul_a    = '0;
    mul_b    = '0;
    unique case (state)
      IDLE: begin
        ready = 1'b1;
        if (sample_valid)
          state_nx = MAC;
      end
      MAC: begin
        coef_idx = k;
        mul_a    = x[k];
        mul_b    = coef;
        if (k == KLAST)
          state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      k       <= '0;
      acc     <= '0;
      y_out   <= '0;
      y_valid <= 1'b0;
      for (int i = 0; i < TAPS; i++)
        x[i] <= '0;
    end else begin
      state   <= state_nx;
      y_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (sample_valid) begin
            x[0] <= sample_in;
            for (int i = 1; i < TAPS; i++)
              x[i] <= x[i-1];
            acc <= '0;
            k   <= '0;
          end
        end
        MAC: begin
          if (k == KLAST) begin
            y_out   <= sum;
            y_valid <= 1'b1;
            k       <= '0;
          end else begin
            acc <= sum;
            k   <= k + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_mac_seq.sv
// Directed bench for fir_mac_seq with a Q5.15 saturating
// multiplier model and coefficient ROM.
module tb_fir_mac_seq;
  localparam int SIZE = 21;
  localparam int TAPS = 8;
  localparam int CW   = 3;

  logic            clk = 1'b0;
  logic            reset;
  logic [SIZE-1:0] sample_in;
  logic            sample_valid;
  logic            ready;
  logic [CW-1:0]   coef_idx;
  logic [SIZE-1:0] coef;
  logic [SIZE-1:0] mul_a;
  logic [SIZE-1:0] mul_b;
  logic [SIZE-1:0] mul_p;
  logic [SIZE-1:0] y_out;
  logic            y_valid;

  logic [SIZE-1:0] rom [TAPS];
  logic [SIZE-1:0] mline [TAPS];
  logic [SIZE-1:0] y_got;
  int              lat;
  int              checks = 0;
  int              errors = 0;

  always #5 clk = ~clk;

  fir_mac_seq #(.SIZE(SIZE), .TAPS(TAPS), .CW(CW)) dut (
    .clk          (clk),
    .reset        (reset),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .ready        (ready),
    .coef_idx     (coef_idx),
    .coef         (coef),
    .mul_a        (mul_a),
    .mul_b        (mul_b),
    .mul_p        (mul_p),
    .y_out        (y_out),
    .y_valid      (y_valid)
  );

  function automatic logic [SIZE-1:0] clamp(input longint v);
    if (v > 64'sd1048575) return 21'h0FFFFF;
    if (v < -64'sd1048576) return 21'h100000;
    return v[SIZE-1:0];
  endfunction

  function automatic logic [SIZE-1:0] qmul(
    input logic [SIZE-1:0] a,
    input logic [SIZE-1:0] b
  );
    longint pa, pb;
    pa = longint'($signed(a));
    pb = longint'($signed(b));
    return clamp((pa * pb) >>> 15);
  endfunction

  function automatic logic [SIZE-1:0] golden();
    logic [SIZE-1:0] s;
    s = '0;
    for (int i = 0; i < TAPS; i++)
      s = clamp(longint'($signed(s)) +
                longint'($signed(qmul(mline[i], rom[i]))));
    return s;
  endfunction

  assign coef  = rom[coef_idx];
  assign mul_p = qmul(mul_a, mul_b);

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sample_valid = 1'($urandom);
      sample_in    = SIZE'($urandom);
      tick();
    end
    reset        = 1'b0;
    sample_valid = 1'b0;
    sample_in    = '0;
  endtask

  task automatic send(input logic [SIZE-1:0] xv);
    int n;
    n = 0;
    while (!ready && n < 40) begin
      tick();
      n++;
    end
    sample_in    = xv;
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
    lat = 0;
    while (!y_valid && lat < 20) begin
      tick();
      lat++;
    end
    y_got = y_out;
  endtask

  initial begin
    int acc_n, y_n, seen;
    logic [SIZE-1:0] e;
    logic            take;
    reset        = 1'b1;
    sample_valid = 1'b0;
    sample_in    = '0;
    for (int i = 0; i < TAPS; i++)
      rom[i] = '0;

    do_reset();
    reset = 1'b1;
    tick();
    check("rst_y", 32'(y_out), 0);
    check("rst_yv", 32'(y_valid), 0);
    check("rst_rdy", 32'(ready), 1);
    check("rst_ma", 32'(mul_a), 0);
    check("rst_mb", 32'(mul_b), 0);
    reset = 1'b0;

    for (int i = 0; i < TAPS; i++)
      rom[i] = SIZE'(i * 32'h1000);
    do_reset();
    for (int i = 0; i < TAPS; i++) begin
      send(i == 0 ? 21'h08000 : 21'h0);
      check($sformatf("imp_y%0d", i), 32'(y_got), 32'(i * 32'h1000));
      check($sformatf("imp_lat%0d", i), 32'(lat), 8);
    end

    for (int i = 0; i < TAPS; i++)
      rom[i] = 21'h08000;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      send(21'h08000);
      e = SIZE'(((i + 1 < 8) ? i + 1 : 8) * 32'h8000);
      check($sformatf("dc_y%0d", i), 32'(y_got), 32'(e));
    end

    do_reset();
    send(21'h080000);
    check("sat_p1", 32'(y_got), 32'h080000);
    send(21'h080000);
    check("sat_p2", 32'(y_got), 32'h0FFFFF);
    do_reset();
    send(21'h180000);
    check("sat_n1", 32'(y_got), 32'h180000);
    send(21'h180000);
    check("sat_n2", 32'(y_got), 32'h100000);

    for (int i = 0; i < TAPS; i++) begin
      rom[i] = (i % 2 == 1) ? 21'h1FE000 : 21'h003000;
      mline[i] = '0;
    end
    do_reset();
    acc_n = 0;
    y_n   = 0;
    for (int c = 0; c < 46; c++) begin
      sample_in    = SIZE'(c * 32'h1100);
      sample_valid = 1'b1;
      take         = ready;
      tick();
      if (take) begin
        for (int i = TAPS - 1; i > 0; i--)
          mline[i] = mline[i-1];
        mline[0] = SIZE'(c * 32'h1100);
        acc_n++;
      end
      if (y_valid) begin
        check($sformatf("bp_y%0d", y_n), 32'(y_out), 32'(golden()));
        y_n++;
      end
    end
    sample_valid = 1'b0;
    check("bp_acc", 32'(acc_n), 6);
    check("bp_ycnt", 32'(y_n), 5);

    for (int i = 0; i < TAPS; i++)
      rom[i] = SIZE'((i + 1) * 32'h1000);
    do_reset();
    sample_in    = 21'h08000;
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
    for (int i = 0; i < 3; i++)
      tick();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (y_valid) seen++;
    end
    check("mid_noyv", 32'(seen), 0);
    check("mid_y0", 32'(y_out), 0);
    send(21'h08000);
    check("mid_y", 32'(y_got), 32'h1000);
    check("mid_lat", 32'(lat), 8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
